// File: rtl/rf_wb_arbiter_pkg.sv
// Shared constants and types for the register-file writeback arbiter.
package rf_wb_arbiter_pkg;

  localparam int ADDR_W = 5;
  localparam int DATA_W = 32;
  localparam int MAX_WAIT = 4;

  localparam logic [4:0] REG_ZERO = 5'd0;

  typedef enum logic [1:0] {
    GNT_NONE = 2'b00,
    GNT_P0   = 2'b01,
    GNT_P1   = 2'b10
  } gnt_e;

endpackage

// File: rtl/rf_wb_arbiter_wb_slot.sv
// One-entry writeback holding register. A load wins over a pop on the same
// edge, so a slot can hand its old entry onward and take a new one without a bubble.
module wb_slot #(
  parameter int ADDR_W = rf_wb_arbiter_pkg::ADDR_W,
  parameter int DATA_W = rf_wb_arbiter_pkg::DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              pop,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [DATA_W-1:0] load_data,
  output logic              full,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] data
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full <= 1'b0;
      addr <= '0;
      data <= '0;
    end else if (load) begin
      full <= 1'b1;
      addr <= load_addr;
      data <= load_data;
    end else if (pop) begin
      full <= 1'b0;
    end
  end

endmodule

// File: rtl/rf_wb_arbiter.sv
// Shares the register file's single write port between the ALU (port 0) and
// the load/mul-div path (port 1) with fixed priority plus aging for port 1.
module rf_wb_arbiter #(
  parameter int ADDR_W   = rf_wb_arbiter_pkg::ADDR_W,
  parameter int DATA_W   = rf_wb_arbiter_pkg::DATA_W,
  parameter int MAX_WAIT = rf_wb_arbiter_pkg::MAX_WAIT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_valid,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_data,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_data,
  output logic              req1_ready,
  output logic              write_ctr,
  output logic [ADDR_W-1:0] write_addr,
  output logic [DATA_W-1:0] write_data,
  input  logic [ADDR_W-1:0] chk_addr,
  output logic              chk_hit,
  output logic              busy
);
  import rf_wb_arbiter_pkg::REG_ZERO, rf_wb_arbiter_pkg::gnt_e;
  import rf_wb_arbiter_pkg::GNT_NONE, rf_wb_arbiter_pkg::GNT_P0, rf_wb_arbiter_pkg::GNT_P1;

  localparam int AGE_W = $clog2(MAX_WAIT + 1);
  localparam logic [ADDR_W-1:0] ZERO_IDX = ADDR_W'(REG_ZERO);

  // Handshake: a port transfers on a posedge where valid and ready are both
  // high; ready depends only on slot state, never on valid.
  logic              full0, full1;
  logic [ADDR_W-1:0] addr0, addr1;
  logic [DATA_W-1:0] data0, data1;
  logic              fill0, fill1;
  logic              gnt0, gnt1;
  logic              keep1;
  logic [AGE_W-1:0]  age1;
  logic              order1;
  gnt_e              gnt;

  wb_slot #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_slot0 (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (fill0),
    .pop       (gnt0),
    .load_addr (req0_addr),
    .load_data (req0_data),
    .full      (full0),
    .addr      (addr0),
    .data      (data0)
  );

  wb_slot #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_slot1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (fill1),
    .pop       (gnt1),
    .load_addr (req1_addr),
    .load_data (req1_data),
    .full      (full1),
    .addr      (addr1),
    .data      (data1)
  );

  // order1 set means slot 1 holds the older entry; it only matters when both
  // slots target the same register, so the later write lands last.
  always_comb begin
    gnt = GNT_NONE;
    if (full0 && full1) begin
      if (age1 >= AGE_W'(MAX_WAIT))
        gnt = GNT_P1;
      else if ((addr0 == addr1) && order1)
        gnt = GNT_P1;
      else
        gnt = GNT_P0;
    end else if (full0) begin
      gnt = GNT_P0;
    end else if (full1) begin
      gnt = GNT_P1;
    end
  end

  assign gnt0 = (gnt == GNT_P0);
  assign gnt1 = (gnt == GNT_P1);

  assign req0_ready = !full0 || gnt0;
  assign req1_ready = !full1 || gnt1;

  // Writes to register 0 complete the handshake but never occupy a slot.
  assign fill0 = req0_valid && req0_ready && (req0_addr != ZERO_IDX);
  assign fill1 = req1_valid && req1_ready && (req1_addr != ZERO_IDX);
  assign keep1 = full1 && !gnt1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      order1 <= 1'b0;
    end else if (fill0 && !fill1) begin
      order1 <= keep1;
    end else if (fill1) begin
      order1 <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      age1 <= '0;
    end else if (!full1 || gnt1) begin
      age1 <= '0;
    end else if (age1 < AGE_W'(MAX_WAIT)) begin
      age1 <= age1 + AGE_W'(1);
    end
  end

  // Registered output stage holds steady through the register file's negedge commit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      write_ctr  <= 1'b0;
      write_addr <= '0;
      write_data <= '0;
    end else begin
      write_ctr <= gnt0 || gnt1;
      if (gnt1) begin
        write_addr <= addr1;
        write_data <= data1;
      end else if (gnt0) begin
        write_addr <= addr0;
        write_data <= data0;
      end
    end
  end

  assign chk_hit = (chk_addr != ZERO_IDX) &&
                   ((full0 && (addr0 == chk_addr)) ||
                    (full1 && (addr1 == chk_addr)) ||
                    (write_ctr && (write_addr == chk_addr)));

  assign busy = full0 || full1 || write_ctr;

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed bench for rf_wb_arbiter: expected register-file writes are queued
// when stimulus is driven and checked as the write port fires.
module tb_rf_wb_arbiter;
  localparam int ADDR_W = 5;
  localparam int DATA_W = 32;
  localparam int W = ADDR_W + DATA_W;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              req0_valid, req1_valid;
  logic [ADDR_W-1:0] req0_addr, req1_addr;
  logic [DATA_W-1:0] req0_data, req1_data;
  logic              req0_ready, req1_ready;
  logic              write_ctr;
  logic [ADDR_W-1:0] write_addr;
  logic [DATA_W-1:0] write_data;
  logic [ADDR_W-1:0] chk_addr;
  logic              chk_hit;
  logic              busy;

  logic [W-1:0]      exp_q[$];
  logic [DATA_W-1:0] rf [0:31];
  int                n_checks = 0;
  int                n_fails  = 0;

  // clock / reset
  always #5 clk = ~clk;

  rf_wb_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_WAIT(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0_valid (req0_valid),
    .req0_addr  (req0_addr),
    .req0_data  (req0_data),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_addr  (req1_addr),
    .req1_data  (req1_data),
    .req1_ready (req1_ready),
    .write_ctr  (write_ctr),
    .write_addr (write_addr),
    .write_data (write_data),
    .chk_addr   (chk_addr),
    .chk_hit    (chk_hit),
    .busy       (busy)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // scoreboard: every write the DUT issues must match the queue head
  always @(negedge clk) begin
    if (rst_n === 1'b1 && write_ctr === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fails++;
        $error("FAIL unexpected_write: observed %0h:%0h expected none", write_addr, write_data);
      end else begin
        check("write", 64'({write_addr, write_data}), 64'(exp_q.pop_front()));
      end
      rf[write_addr] = write_data;
    end
  end

  // driver: drive at negedge+1, transfer decided at the next posedge
  task automatic step(input logic v0, input logic [ADDR_W-1:0] a0, input logic [DATA_W-1:0] d0,
                      input logic v1, input logic [ADDR_W-1:0] a1, input logic [DATA_W-1:0] d1,
                      output logic t0, output logic t1);
    req0_valid = v0; req0_addr = a0; req0_data = d0;
    req1_valid = v1; req1_addr = a1; req1_data = d1;
    t0 = v0 && req0_ready;
    t1 = v1 && req1_ready;
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  task automatic idle();
    logic t0, t1;
    step(1'b0, '0, '0, 1'b0, '0, '0, t0, t1);
  endtask

  task automatic drain(input string tag, input int budget);
    for (int i = 0; i < budget && exp_q.size() != 0; i++) idle();
    check({tag, "_drain"}, 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic t0, t1;
    int   cnt0, cnt1;

    rst_n = 1'b0;
    req0_valid = 1'b0; req0_addr = '0; req0_data = '0;
    req1_valid = 1'b0; req1_addr = '0; req1_data = '0;
    chk_addr = '0;
    for (int i = 0; i < 32; i++) rf[i] = '0;

    @(posedge clk);
    @(negedge clk);
    #1;
    check("rst_write_ctr", 64'(write_ctr), 64'd0);
    check("rst_write_addr", 64'(write_addr), 64'd0);
    check("rst_write_data", 64'(write_data), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_ready0", 64'(req0_ready), 64'd1);
    check("rst_ready1", 64'(req1_ready), 64'd1);
    rst_n = 1'b1;
    @(negedge clk);
    #1;

    // 1: single port-0 write, latency and busy
    exp_q.push_back({5'd3, 32'hA5});
    step(1'b1, 5'd3, 32'hA5, 1'b0, '0, '0, t0, t1);
    check("t1_xfer", 64'(t0), 64'd1);
    check("t1_ctr_early", 64'(write_ctr), 64'd0);
    check("t1_busy_slot", 64'(busy), 64'd1);
    idle();
    check("t1_ctr", 64'(write_ctr), 64'd1);
    check("t1_addr", 64'(write_addr), 64'd3);
    check("t1_data", 64'(write_data), 64'hA5);
    idle();
    check("t1_ctr_off", 64'(write_ctr), 64'd0);
    check("t1_busy_off", 64'(busy), 64'd0);

    // 2: both ports streaming; grant pattern 0,0,0,0,1
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 4; i++) exp_q.push_back({5'd5, 32'h1000 + 32'(4 * r + i)});
      exp_q.push_back({5'd6, 32'h2000 + 32'(r)});
    end
    cnt0 = 0;
    cnt1 = 0;
    for (int c = 0; c < 100 && (cnt0 < 12 || cnt1 < 3); c++) begin
      step(cnt0 < 12, 5'd5, 32'h1000 + 32'(cnt0), cnt1 < 3, 5'd6, 32'h2000 + 32'(cnt1), t0, t1);
      if (t0) cnt0++;
      if (t1) cnt1++;
    end
    check("t2_cnt0", 64'(cnt0), 64'd12);
    check("t2_cnt1", 64'(cnt1), 64'd3);
    drain("t2", 20);

    // 3: port 1 then port 0 to the same register
    exp_q.push_back({5'd7, 32'h71});
    exp_q.push_back({5'd7, 32'h70});
    step(1'b0, '0, '0, 1'b1, 5'd7, 32'h71, t0, t1);
    check("t3_xfer1", 64'(t1), 64'd1);
    step(1'b1, 5'd7, 32'h70, 1'b0, '0, '0, t0, t1);
    check("t3_xfer0", 64'(t0), 64'd1);
    drain("t3", 10);
    check("t3_rf7", 64'(rf[7]), 64'h70);

    // 3b: both slots hold r7, port 1's entry is older and must go first
    exp_q.push_back({5'd4, 32'h40});
    exp_q.push_back({5'd7, 32'h77});
    exp_q.push_back({5'd7, 32'h07});
    step(1'b1, 5'd4, 32'h40, 1'b1, 5'd7, 32'h77, t0, t1);
    check("t3b_xfer_both", 64'({t0, t1}), 64'b11);
    step(1'b1, 5'd7, 32'h07, 1'b0, '0, '0, t0, t1);
    check("t3b_xfer0", 64'(t0), 64'd1);
    drain("t3b", 10);
    check("t3b_rf7", 64'(rf[7]), 64'h07);

    // 4: register 0 requests are accepted and dropped
    step(1'b1, 5'd0, 32'hFFFF, 1'b1, 5'd0, 32'hFFFF, t0, t1);
    check("t4_xfer", 64'({t0, t1}), 64'b11);
    check("t4_busy_a", 64'(busy), 64'd0);
    idle();
    check("t4_ctr", 64'(write_ctr), 64'd0);
    check("t4_busy_b", 64'(busy), 64'd0);

    // 5: hazard query across slot and output stage
    chk_addr = 5'd9;
    #1;
    check("t5_hit_empty", 64'(chk_hit), 64'd0);
    exp_q.push_back({5'd9, 32'h99});
    step(1'b0, '0, '0, 1'b1, 5'd9, 32'h99, t0, t1);
    check("t5_hit_slot", 64'(chk_hit), 64'd1);
    idle();
    check("t5_ctr", 64'(write_ctr), 64'd1);
    check("t5_hit_out", 64'(chk_hit), 64'd1);
    chk_addr = 5'd0;
    #1;
    check("t5_hit_zero", 64'(chk_hit), 64'd0);
    chk_addr = 5'd9;
    idle();
    check("t5_hit_clear", 64'(chk_hit), 64'd0);

    // 6: async reset with both slots full and a write in flight
    exp_q.push_back({5'd10, 32'h10});
    step(1'b1, 5'd10, 32'h10, 1'b1, 5'd11, 32'h11, t0, t1);
    step(1'b1, 5'd12, 32'h12, 1'b0, '0, '0, t0, t1);
    check("t6_refill", 64'(t0), 64'd1);
    check("t6_ctr_pre", 64'(write_ctr), 64'd1);
    check("t6_ready1_pre", 64'(req1_ready), 64'd0);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    chk_addr = 5'd11;
    rst_n = 1'b0;
    #1;
    check("t6_ctr", 64'(write_ctr), 64'd0);
    check("t6_addr", 64'(write_addr), 64'd0);
    check("t6_data", 64'(write_data), 64'd0);
    check("t6_busy", 64'(busy), 64'd0);
    check("t6_hit", 64'(chk_hit), 64'd0);
    check("t6_ready", 64'({req0_ready, req1_ready}), 64'b11);
    @(negedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) idle();
    check("t6_busy_after", 64'(busy), 64'd0);
    check("final_queue", 64'(exp_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
